// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for param_ram and its read pipeline.
package ram_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  function automatic int lanes(input int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/ram_read_pipe.sv
// ram_read_pipe: 1- or 2-stage register chain carrying read data, valid and range error.
module ram_read_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);
  logic [STAGES-1:0] v, e;
  logic [WIDTH-1:0] d [STAGES];
  // data stages only load on valid so the output holds between reads
  always_ff @(posedge clock)
    if (!resetn) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid && in_err;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  assign out_valid = v[STAGES-1];
  assign out_err = e[STAGES-1];
  assign out_data = d[STAGES-1];
endmodule

// File: rtl/param_ram.sv
// param_ram: parametrised single-port RAM with byte lanes, RDW policy and 1/2-stage read pipe.
// Define RAM_CLEAR_EN to zero-fill the array after every reset before accepting requests.
module param_ram import ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RDW_MODE = RDW_OLD,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        memRead,
  input  logic                        memWrite,
  input  logic [lanes(DATA_WIDTH)-1:0] byteEn,
  input  logic [ADDR_WIDTH-1:0]       address,
  input  logic [DATA_WIDTH-1:0]       dataIn,
  output logic [DATA_WIDTH-1:0]       dataOut,
  output logic                        readValid,
  output logic                        ready,
  output logic                        addrErr
);
  localparam int LANES = lanes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  if (DATA_WIDTH % 8 != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2) || DEPTH > 2**ADDR_WIDTH) begin : g_bad_params
    $error("param_ram: illegal parameter combination");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word, merged, rd_word;
  logic oob, rd_acc, wr_acc, wr_err, pipe_err, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  assign oob = {1'b0, address} >= DEPTH_A;
  assign rd_acc = ready && resetn && memRead;
  assign wr_acc = ready && resetn && memWrite && |byteEn;
  assign old_word = mem[address];
  always_comb begin
    merged = old_word;
    for (int i = 0; i < LANES; i++) if (byteEn[i]) merged[8*i +: 8] = dataIn[8*i +: 8];
  end
  assign rd_word = oob ? '0 : (RDW_MODE == RDW_NEW && wr_acc) ? merged : old_word;
  always_ff @(posedge clock)
    if (clr_we) mem[clr_addr] <= '0;
    else if (wr_acc && !oob)
      for (int i = 0; i < LANES; i++) if (byteEn[i]) mem[address][8*i +: 8] <= dataIn[8*i +: 8];
  // a dropped out-of-range write reports in the cycle after acceptance, independent of read latency
  always_ff @(posedge clock)
    if (!resetn) wr_err <= 1'b0;
    else wr_err <= wr_acc && oob;
  ram_read_pipe #(.WIDTH(DATA_WIDTH), .STAGES(READ_LATENCY)) u_pipe (
    .clock(clock), .resetn(resetn), .in_valid(rd_acc), .in_err(oob), .in_data(rd_word),
    .out_valid(readValid), .out_err(pipe_err), .out_data(dataOut)
  );
  assign addrErr = wr_err || pipe_err;
`ifdef RAM_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_n;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
    end
  always_comb state_n = (state == CLEAR && clr_cnt == LAST) ? RUN : state;
  assign ready = state == RUN;
  assign clr_we = state == CLEAR;
  assign clr_addr = clr_cnt;
`else
  always_ff @(posedge clock) ready <= resetn;
  assign clr_we = 1'b0;
  assign clr_addr = '0;
`endif
endmodule

// File: doc/param_ram.md
# param_ram

Parametrised single-port synchronous RAM that succeeds the fixed 512 x 32 data memory in the CPU datapath. It adds configurable width and depth, byte-lane write enables, a selectable read-during-write policy, a one- or two-stage read pipeline with a valid strobe, out-of-range address detection, and an optional hardware zero-fill after reset. It sits between the CPU load/store unit and the memory map. The load/store unit gates all requests on `ready`.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- DEPTH, 512, number of words
- ADDR_WIDTH, $clog2(DEPTH), address bus width
- RDW_MODE, 0, read-during-write to the same address: 0 returns the old data, 1 returns the newly written (merged) data
- READ_LATENCY, 1, read pipeline depth; legal values are 1 or 2

Ports:
- clock  in  1  the single clock; all logic is on its rising edge
- resetn  in  1  reset; synchronous and active-low
- memRead  in  1  read request
- memWrite  in  1  write request
- byteEn  in  DATA_WIDTH/8  write lane enables; bit i covers dataIn[8i+7:8i]
- address  in  ADDR_WIDTH  word address
- dataIn  in  DATA_WIDTH  write data
- dataOut  out  DATA_WIDTH  read data; valid when readValid=1
- readValid  out  1  one-cycle strobe for each accepted read
- ready  out  1  block is accepting requests
- addrErr  out  1  one-cycle strobe for an accepted request whose address is >= DEPTH

## Operation
- Two-state FSM:
  - CLEAR: zero-fill. Exists only when RAM_CLEAR_EN is defined.
  - RUN: normal operation.
- Requests are accepted only when ready=1. When ready=0, memRead and memWrite are ignored, with no side effects.
- Accepted write:
  - Lanes with byteEn[i]=1 are updated. Other lanes keep their contents.
  - byteEn all zero is a no-op write, with no addrErr check.
- Accepted read: memory word → pipeline → dataOut. readValid asserts on the same cycle dataOut updates.
- Read and write in the same cycle are both performed.
  - Different addresses: the two operations are independent.
  - Same address: RDW_MODE selects the returned data, with byte-merge applied for mode 1.
- Address >= DEPTH (non-power-of-two DEPTH):
  - The write is dropped.
  - A read returns all zeros with readValid=1.
  - addrErr pulses aligned with the request's response slot. For a write, that slot is the cycle after acceptance.
- dataOut holds its last value between reads and does not clear when readValid drops.
- Back-to-back reads: one per cycle, full throughput, responses returned in order.

## Timing
- Reset values: dataOut=0, readValid=0, addrErr=0. ready=0 while resetn=0.
- After resetn rises, without RAM_CLEAR_EN: ready=1 on the first clock edge.
- Read latency: read accepted at edge N → dataOut and readValid valid after edge N+READ_LATENCY.
- Write visible to a read accepted at edge N+1, or at edge N under RDW_MODE=1.
- Reset asserted mid-operation:
  - The read pipeline flushes. In-flight reads produce no readValid.
  - Writes accepted before the reset edge are completed.
  - Memory contents are not reset, except by CLEAR.
- Simultaneous reset and request: reset wins; the request is dropped.

## Configuration
- RAM_CLEAR_EN defined:
  - After reset the FSM enters CLEAR with ready=0.
  - An internal counter writes zero to addresses 0..DEPTH-1, one word per cycle.
  - ready=1 exactly DEPTH cycles after the resetn deassertion edge.
  - Reset during CLEAR restarts the counter at 0.
- RAM_CLEAR_EN undefined:
  - No CLEAR state and no counter.
  - Memory powers up undefined.
  - ready follows resetn, one cycle late.

## Structure
- Shared package ram_pkg:
  - State enum {CLEAR, RUN}.
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - Function lanes(w)=w/8.
- One sub-module, ram_read_pipe: parametrised 1/2-stage register chain for data, valid and err. The top level holds the array, lane merge, RDW mux, FSM and clear counter.
- Elaboration checks: DATA_WIDTH%8==0, READ_LATENCY in {1,2}, DEPTH<=2**ADDR_WIDTH.

## Test plan
- Reset, defaults, RAM_CLEAR_EN: hold resetn=0 for 3 cycles → outputs 0. After release, ready rises exactly 512 cycles later. A read of address 0x1FF → dataOut=0x00000000.
- Byte enables: write 0xDEADBEEF to address 5 with byteEn=4'b1111, then 0x11223344 with byteEn=4'b0101. Read address 5 → 0xDE22BE44, with readValid exactly 1 cycle after acceptance.
- RDW, same address 7, old data 0xAAAAAAAA, write 0x55555555 with a simultaneous read:
  - RDW_MODE=0 → read returns 0xAAAAAAAA.
  - RDW_MODE=1 → read returns 0x55555555.
  - A following read returns 0x55555555 in both modes.
- READ_LATENCY=2 streaming: reads of addresses 0,1,2,3 on consecutive cycles → four consecutive readValid pulses, starting 2 cycles after the first, data in order.
- Range error, DEPTH=500: write 0x12345678 to address 505 → addrErr pulse, memory unchanged. Read 505 → dataOut=0, readValid=1, addrErr=1 on the same cycle.
- Mid-operation reset:
  - Issue a read, then assert resetn=0 on the next edge → no readValid; a prior write to address 3 persists after reset (without RAM_CLEAR_EN).
  - With RAM_CLEAR_EN, assert reset at CLEAR count 100 → ready rises DEPTH cycles after the new release.
